twos_to_signmag_serial: RTL and testbench

Bit-serial decoder that converts a WIDTH-bit two's-complement word into sign-magnitude form. It is the inverse direction of the team's combinational invert-plus-one negator, which encodes a magnitude as its two's-complement negative. Each accepted word is processed LSB-first, one bit per clock, using the same carry-chain rule as the negator: copy bits up to and including the first 1, then invert every higher bit. The block sits between a two's-complement producer and a sign-magnitude consumer (for example, the seven-segment display path), with valid/ready handshakes on both sides.

---
 rtl/twos_to_signmag_serial_if.sv | 38 +++
 rtl/twos_to_signmag_serial.sv | 139 +++++++++++++
 tb/tb_twos_to_signmag_serial.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/twos_to_signmag_serial_if.sv
// Handshake bundle between a two's-complement producer, the serial
// sign-magnitude decoder and its sign-magnitude consumer.
interface twos_to_signmag_serial_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             out_minneg;

  // Producer/consumer side of the bundle.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sign,
    input  out_mag,
    input  out_minneg
  );

  // Decoder side of the bundle.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sign,
    output out_mag,
    output out_minneg
  );
endinterface

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB-first:
// copy bits up to and including the first 1, invert the rest when negative.
module twos_to_signmag_serial #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  twos_to_signmag_serial_if.slave bus,
  output logic                    busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A negative word flips every bit above the first 1 seen from the LSB.
  function automatic logic conv_bit(input logic b, input logic sign, input logic seen);
    conv_bit = b ^ (sign & seen);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic             sign_r, sign_s;
  logic             seen_r, seen_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             out_sign_r, out_sign_s;
  logic [WIDTH-1:0] out_mag_r, out_mag_s;
  logic             out_minneg_r, out_minneg_s;
  logic             out_valid_r, out_valid_s;
  logic             in_ready_r, in_ready_s;
  logic             busy_r, busy_s;
  logic             r_bit_s;
  logic [WIDTH-1:0] res_shift_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    res_s        = res_r;
    sign_s       = sign_r;
    seen_s       = seen_r;
    cnt_s        = cnt_r;
    out_sign_s   = out_sign_r;
    out_mag_s    = out_mag_r;
    out_minneg_s = out_minneg_r;
    r_bit_s      = conv_bit(shreg_r[0], sign_r, seen_r);
    res_shift_s  = {r_bit_s, res_r[WIDTH-1:1]};

    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_s = ST_SHIFT;
          shreg_s = bus.in_data;
          sign_s  = bus.in_data[WIDTH-1];
          seen_s  = 1'b0;
          cnt_s   = '0;
          res_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
        res_s   = res_shift_s;
        seen_s  = seen_r | shreg_r[0];
        cnt_s   = cnt_r + CW'(1);
        if (cnt_r == LAST_CNT) begin
          state_s      = ST_DONE;
          out_sign_s   = sign_r;
          out_mag_s    = res_shift_s;
          // Only 100..0 decodes to magnitude 100..0 with the sign set.
          out_minneg_s = sign_r && (res_shift_s == MINNEG);
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    in_ready_s  = (state_s == ST_IDLE);
    out_valid_s = (state_s == ST_DONE);
    busy_s      = (state_s != ST_IDLE);
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shreg_r      <= '0;
      res_r        <= '0;
      sign_r       <= 1'b0;
      seen_r       <= 1'b0;
      cnt_r        <= '0;
      out_sign_r   <= 1'b0;
      out_mag_r    <= '0;
      out_minneg_r <= 1'b0;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      res_r        <= res_s;
      sign_r       <= sign_s;
      seen_r       <= seen_s;
      cnt_r        <= cnt_s;
      out_sign_r   <= out_sign_s;
      out_mag_r    <= out_mag_s;
      out_minneg_r <= out_minneg_s;
      out_valid_r  <= out_valid_s;
      in_ready_r   <= in_ready_s;
      busy_r       <= busy_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_sign   = out_sign_r;
  assign bus.out_mag    = out_mag_r;
  assign bus.out_minneg = out_minneg_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial: an arithmetic reference model is
// compared every cycle, and hand-computed literals pin the key results.
module tb_twos_to_signmag_serial;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  twos_to_signmag_serial_if #(.WIDTH(W)) bus ();

  twos_to_signmag_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: transaction timing plus plain signed arithmetic.
  logic         m_live = 1'b0;
  logic         m_busy, m_valid, m_sign, m_minneg;
  logic [W-1:0] m_word, m_mag;
  int           m_cnt;

  always @(negedge clk) begin
    int v;
    if (m_live) begin
      chk("in_ready",   32'(bus.in_ready),   32'(!m_busy));
      chk("busy",       32'(busy),           32'(m_busy));
      chk("out_valid",  32'(bus.out_valid),  32'(m_valid));
      chk("out_sign",   32'(bus.out_sign),   32'(m_sign));
      chk("out_mag",    32'(bus.out_mag),    32'(m_mag));
      chk("out_minneg", 32'(bus.out_minneg), 32'(m_minneg));
    end
    if (rst) begin
      m_live = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
      m_sign = 1'b0; m_mag = '0; m_minneg = 1'b0; m_word = '0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy = 1'b1; m_word = bus.in_data; m_cnt = W;
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          v         = int'($signed(m_word));
          m_valid   = 1'b1;
          m_sign    = (v < 0);
          m_mag     = W'((v < 0) ? -v : v);
          m_minneg  = (v == -(1 << (W - 1)));
        end
      end else if (bus.out_ready) begin
        m_valid = 1'b0; m_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  // Accept one word, check latency and the literal result, then drain it.
  task automatic send(input logic [W-1:0] word, input logic es, input logic [W-1:0] em, input logic en);
    int lat;
    bus.in_data  = word;
    bus.in_valid = 1'b1;
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("latency",  32'(lat),            32'd4);
    chk("lit_sign", 32'(bus.out_sign),   32'(es));
    chk("lit_mag",  32'(bus.out_mag),    32'(em));
    chk("lit_min",  32'(bus.out_minneg), 32'(en));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
  endtask

  logic [W-1:0] b2b_w [3];
  logic [W-1:0] b2b_m [3];
  logic         b2b_s [3];
  int           t_valid [3];

  initial begin
    int lat;
    int guard;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mag",       32'(bus.out_mag),   32'd0);
    chk("rst_busy",      32'(busy),          32'd0);

    send(4'b0101, 1'b0, 4'b0101, 1'b0);
    send(4'b1011, 1'b1, 4'b0101, 1'b0);
    send(4'b1111, 1'b1, 4'b0001, 1'b0);
    send(4'b1000, 1'b1, 4'b1000, 1'b1);
    send(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Backpressure with a competing word on the input side.
    bus.in_data = 4'b0110; bus.in_valid = 1'b1;
    step();
    bus.in_data = 4'b1001;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_ready", 32'(bus.in_ready),  32'd0);
      chk("bp_mag",   32'(bus.out_mag),   32'(4'b0110));
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_after_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_after_busy",  32'(busy),         32'd0);

    // Reset after two bits of a word in flight.
    bus.in_data = 4'b1110; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready),  32'd1);
    chk("midrst_busy",  32'(busy),          32'd0);
    send(4'b1110, 1'b1, 4'b0010, 1'b0);

    // Back-to-back with both handshakes held high.
    b2b_w[0] = 4'b0011; b2b_s[0] = 1'b0; b2b_m[0] = 4'b0011;
    b2b_w[1] = 4'b1101; b2b_s[1] = 1'b1; b2b_m[1] = 4'b0011;
    b2b_w[2] = 4'b0111; b2b_s[2] = 1'b0; b2b_m[2] = 4'b0111;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = b2b_w[k];
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        step();
        guard++;
      end
      chk("b2b_ready", 32'(bus.in_ready), 32'd1);
      step();
      wait_valid(lat);
      t_valid[k] = cyc;
      chk("b2b_sign", 32'(bus.out_sign), 32'(b2b_s[k]));
      chk("b2b_mag",  32'(bus.out_mag),  32'(b2b_m[k]));
    end
    bus.in_valid = 1'b0;
    step(); step();
    chk("b2b_gap01", 32'(t_valid[1] - t_valid[0]), 32'd6);
    chk("b2b_gap12", 32'(t_valid[2] - t_valid[1]), 32'd6);
    bus.out_ready = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
